ssd_scan_driver: RTL and testbench
==================================

Name: ssd_scan_driver

Overview:
Parametrised multi-digit seven-segment display driver. It is the time-multiplexed successor to the single-digit BCD/hex decoder. It latches a packed nibble vector, scans DIGITS common-anode digits one at a time, decodes each nibble to GFEDCBA active-low segments, and drives per-digit decimal points. It adds leading-zero blanking, a BCD mode with out-of-range indication, and a one-cycle anti-ghosting blank at every digit change. It sits between datapath counters/registers and the board's shared segment bus and anode lines.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..8.
REFRESH_DIV, 50000, clock cycles each digit is held; legal minimum 2.

Ports:
Clock  input  1  system clock; all state changes on its rising edge.
Reset  input  1  synchronous, active-high reset.
Value  input  4*DIGITS  packed nibbles; digit i is bits [4i+3:4i]; digit 0 is rightmost.
Load  input  1  when high, Value and DpMask are captured into the shadow registers.
DpMask  input  DIGITS  bit i high lights the decimal point of digit i; captured with Load.
BcdMode  input  1  when high, nibbles 10..15 display a dash; when low, they display hex A-F.
BlankLeading  input  1  when high, leading-zero blanking is enabled.
Enable  input  1  when low, all anodes are forced off; the scan continues.
Segments  output  7  GFEDCBA, active-low, bit 6 = G, bit 0 = A.
Dp  output  1  decimal point, active-low.
Anodes  output  DIGITS  digit enables, active-low, at most one low at a time.
Strobe  output  1  one-cycle pulse when the digit index advances.

Behaviour:
- Reset (synchronous, active-high): PreCnt=0, DigitIdx=0, shadow Value=0, shadow DpMask=0, Segments=7'b1111111, Dp=1, Anodes=all ones, Strobe=0. Reset asserted mid-scan aborts the scan and takes effect on the next edge.
- Shadow registers: on Load, capture Value and DpMask. A Load coinciding with Reset loses to Reset. Between Loads the shadow registers hold.
- Prescaler: PreCnt counts 0..REFRESH_DIV-1 and is $clog2(REFRESH_DIV) bits wide. When PreCnt==REFRESH_DIV-1, PreCnt wraps to 0 and DigitIdx increments, wrapping from DIGITS-1 to 0. DIGITS=1 keeps DigitIdx at 0.
- Strobe is registered and goes high in the cycle after the wrap edge, i.e. coincident with PreCnt==0.
- Outputs are registered from the current PreCnt, DigitIdx and shadow registers, giving one cycle of latency.
  - Guard: when PreCnt==0 or Enable==0, Anodes=all ones, Segments=7'b1111111, Dp=1.
  - Otherwise, Anodes has bit DigitIdx low and all other bits high, and Segments=decode(nibble[DigitIdx]).
- Decode (hex): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Decode (BcdMode=1): nibbles 10..15 give 0111111 (G only). Digits 0..9 are unchanged.
- Leading-zero blanking: digit i>0 is blank (Segments=1111111) when BlankLeading=1 and nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked, so a value of 0 shows a single "0". Its anode is still driven.
- Dp = ~DpMask[DigitIdx] when not in the guard condition. Dp is independent of blanking.
- Load during a digit's dwell: the new nibble appears on Segments on the second edge after the Load edge.
- Full cycle time: DIGITS*REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV-1 cycles.

Decomposition:
- Shared package: the SEG_* 7-bit active-low glyph constants (16 hex glyphs, SEG_DASH, SEG_BLANK).
- Sub-module ssd_glyph_rom: combinational nibble + BcdMode -> GFEDCBA glyph. Instantiated once and fed by the DigitIdx mux.
- Top level: prescaler, index counter, shadow registers, blanking logic, output registers.

Test Plan:
Use DIGITS=4 and REFRESH_DIV=4 throughout.
1. Reset release: Reset high for 3 cycles, then low. Outputs are all ones during reset. The first Strobe comes 4 cycles after release. Anodes step 1110, 1101, 1011, 0111 with an 1111 guard cycle before each digit.
2. Hex scan: Load Value=16'hA5F0, BcdMode=0, BlankLeading=0. Digits 0..3 show 1000000, 0001110, 0010010, 0001000.
3. BCD dash: Value=16'h12C9, BcdMode=1. Digit 1 shows 0111111 and digit 0 shows 0010000. With BcdMode=0, digit 1 shows 1000110.
4. Leading zeros: Value=16'h0030, BlankLeading=1. Digits 3 and 2 show 1111111 with their anodes low, digit 1 shows 0110000, digit 0 shows 1000000. Value=0 shows only digit 0 as 1000000.
5. Dp and Enable: DpMask=4'b0100 gives Dp=0 only while Anodes=1011. Enable=0 for 8 cycles keeps Anodes=1111 while Strobe keeps pulsing every 4 cycles.
6. Mid-scan events: Load 16'h1111 on DigitIdx=2 at PreCnt=1, so Segments for digit 2 are 1111001 two edges later. Reset at PreCnt=2 returns all outputs to ones on the next edge and restarts the scan at DigitIdx=0.

Source files
------------

// File: rtl/ssd_scan_driver_pkg.sv
// Shared glyph constants for the seven-segment scan driver.
// All glyphs are GFEDCBA, active-low (bit 6 = G, bit 0 = A).
package ssd_scan_driver_pkg;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/ssd_scan_driver_glyph_rom.sv
// Nibble to active-low GFEDCBA glyph; BCD mode turns 10..15 into a dash.
module ssd_glyph_rom
  import ssd_scan_driver_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_bcd_mode,
  output logic [6:0] o_glyph
);
  always_comb begin
    o_glyph = SEG_BLANK;
    if (i_bcd_mode && (i_nibble > 4'd9)) begin
      o_glyph = SEG_DASH;
    end else begin
      case (i_nibble)
        4'h0: o_glyph = SEG_0;
        4'h1: o_glyph = SEG_1;
        4'h2: o_glyph = SEG_2;
        4'h3: o_glyph = SEG_3;
        4'h4: o_glyph = SEG_4;
        4'h5: o_glyph = SEG_5;
        4'h6: o_glyph = SEG_6;
        4'h7: o_glyph = SEG_7;
        4'h8: o_glyph = SEG_8;
        4'h9: o_glyph = SEG_9;
        4'hA: o_glyph = SEG_A;
        4'hB: o_glyph = SEG_B;
        4'hC: o_glyph = SEG_C;
        4'hD: o_glyph = SEG_D;
        4'hE: o_glyph = SEG_E;
        4'hF: o_glyph = SEG_F;
        default: o_glyph = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode display driver: prescaler, digit scan, shadow
// registers, leading-zero blanking and registered active-low outputs.
module ssd_scan_driver
  import ssd_scan_driver_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic                  i_load,
  input  logic [DIGITS-1:0]     i_dp_mask,
  input  logic                  i_bcd_mode,
  input  logic                  i_blank_leading,
  input  logic                  i_enable,
  output logic [6:0]            o_segments,
  output logic                  o_dp,
  output logic [DIGITS-1:0]     o_anodes,
  output logic                  o_strobe
);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]       r_pre;
  logic [IDX_W-1:0]       r_idx;
  logic [DIGITS-1:0][3:0] r_value;
  logic [DIGITS-1:0]      r_dp_mask;
  logic [6:0]             r_segments;
  logic                   r_dp;
  logic [DIGITS-1:0]      r_anodes;
  logic                   r_strobe;

  logic                   w_wrap;
  logic                   w_guard;
  logic [3:0]             w_nibble;
  logic [6:0]             w_glyph;
  logic [DIGITS-1:0]      w_blank;
  logic [DIGITS-1:0]      w_onehot;

  assign w_wrap   = (r_pre == PRE_MAX);
  // PreCnt==0 doubles as the anti-ghosting blank right after each digit change
  assign w_guard  = (r_pre == '0) || !i_enable;
  assign w_nibble = r_value[r_idx];
  assign w_onehot = DIGITS'(1) << r_idx;

  ssd_glyph_rom u_rom (
    .i_nibble  (w_nibble),
    .i_bcd_mode(i_bcd_mode),
    .o_glyph   (w_glyph)
  );

  // Digit i blanks when it and every more-significant nibble are zero
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_lsd
      assign w_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_blank[gi] = i_blank_leading && (r_value[DIGITS-1:gi] == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre      <= '0;
      r_idx      <= '0;
      r_value    <= '0;
      r_dp_mask  <= '0;
      r_segments <= SEG_BLANK;
      r_dp       <= 1'b1;
      r_anodes   <= '1;
      r_strobe   <= 1'b0;
    end else begin
      r_pre    <= w_wrap ? '0 : r_pre + PRE_W'(1);
      r_strobe <= w_wrap;
      if (w_wrap) r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
      if (i_load) begin
        r_value   <= i_value;
        r_dp_mask <= i_dp_mask;
      end
      if (w_guard) begin
        r_anodes   <= '1;
        r_segments <= SEG_BLANK;
        r_dp       <= 1'b1;
      end else begin
        r_anodes   <= ~w_onehot;
        r_segments <= w_blank[r_idx] ? SEG_BLANK : w_glyph;
        r_dp       <= ~r_dp_mask[r_idx];
      end
    end
  end

  assign o_segments = r_segments;
  assign o_dp       = r_dp;
  assign o_anodes   = r_anodes;
  assign o_strobe   = r_strobe;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs tagged with a
// cycle number; a negedge monitor pops and compares them.
module tb_ssd_scan_driver;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G5 = 7'b0010010, G9 = 7'b0010000,
                         GA = 7'b0001000, GC = 7'b1000110, GF = 7'b0001110,
                         GDASH = 7'b0111111, GBL = 7'b1111111;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       stb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        bcd = 1'b0;
  logic        blank = 1'b0;
  logic        en = 1'b1;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  anodes;
  logic        strobe;

  int cyc = 0;
  int rel = 0;     // cycle at whose #1 point reset was last released
  int total = 0;
  int passed = 0;
  exp_t q[$];

  ssd_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_value(value), .i_load(load),
    .i_dp_mask(dp_mask), .i_bcd_mode(bcd), .i_blank_leading(blank),
    .i_enable(en), .o_segments(segments), .o_dp(dp), .o_anodes(anodes),
    .o_strobe(strobe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        total++;
        if (e.cyc < cyc) begin
          $display("FAIL %s cyc%0d: expectation not sampled (now cyc%0d)", e.name, e.cyc, cyc);
        end else if ({anodes, segments, dp, strobe} !== {e.an, e.seg, e.dp, e.stb}) begin
          $display("FAIL %s cyc%0d: got an=%b seg=%b dp=%b stb=%b, want an=%b seg=%b dp=%b stb=%b",
                   e.name, e.cyc, anodes, segments, dp, strobe, e.an, e.seg, e.dp, e.stb);
        end else begin
          passed++;
        end
      end
    end
  end

  task automatic push(input string name, input int c, input logic [3:0] an,
                      input logic [6:0] seg, input logic d, input logic s);
    exp_t e;
    e.cyc = c; e.name = name; e.an = an; e.seg = seg; e.dp = d; e.stb = s;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      total += q.size();
      q.delete();
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    load = 1'b1; value = v; dp_mask = m;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // One full scan (16 cycles) starting at the next digit-0 guard cycle.
  // g[d] is the hand-decoded glyph expected on digit d.
  task automatic run_scan(input string name, input logic [3:0][6:0] g,
                          input logic [3:0] m, input logic enb);
    int b;
    b = rel + 1;
    while (b < cyc + 1) b += 16;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0 || !enb) push(name, b + 4*d + k, 4'b1111, GBL, 1'b1, k == 3);
        else push(name, b + 4*d + k, ~(4'b0001 << d), g[d], ~m[d], k == 3);
      end
    end
    drain();
  endtask

  initial begin : stim
    int c0;
    // 1: reset held for three edges, then the scan starts from digit 0
    for (int c = 1; c <= 3; c++) push("reset", c, 4'b1111, GBL, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; rel = cyc;
    run_scan("reset_scan", {G0, G0, G0, G0}, 4'b0000, 1'b1);

    // 2: hex scan
    do_load(16'hA5F0, 4'b0000);
    run_scan("hex", {GA, G5, GF, G0}, 4'b0000, 1'b1);

    // 3: BCD dash versus hex C
    bcd = 1'b1;
    do_load(16'h12C9, 4'b0000);
    run_scan("bcd_dash", {G1, G2, GDASH, G9}, 4'b0000, 1'b1);
    bcd = 1'b0;
    run_scan("bcd_off", {G1, G2, GC, G9}, 4'b0000, 1'b1);

    // 4: leading-zero blanking
    blank = 1'b1;
    do_load(16'h0030, 4'b0000);
    run_scan("lead_0030", {GBL, GBL, G3, G0}, 4'b0000, 1'b1);
    do_load(16'h0000, 4'b0000);
    run_scan("lead_zero", {GBL, GBL, GBL, G0}, 4'b0000, 1'b1);
    blank = 1'b0;

    // 5: decimal point on digit 2, then Enable low with the scan running
    do_load(16'h0000, 4'b0100);
    run_scan("dp", {G0, G0, G0, G0}, 4'b0100, 1'b1);
    en = 1'b0;
    run_scan("disable", {G0, G0, G0, G0}, 4'b0100, 1'b0);
    en = 1'b1;

    // 6: Load while digit 2 is at PreCnt=1, then reset at PreCnt=2 of digit 3
    c0 = cyc + 1;
    while ((c0 - rel) % 16 != 9) c0++;
    while (cyc < c0) begin @(posedge clk); #1; end
    load = 1'b1; value = 16'h1111; dp_mask = 4'b0000;
    push("midload", c0 + 1, 4'b1011, G0,    1'b0, 1'b0);
    push("midload", c0 + 2, 4'b1011, G1,    1'b1, 1'b0);
    push("midload", c0 + 3, 4'b1011, G1,    1'b1, 1'b1);
    push("midload", c0 + 4, 4'b1111, GBL,   1'b1, 1'b0);
    push("midload", c0 + 5, 4'b0111, G1,    1'b1, 1'b0);
    push("midreset", c0 + 6, 4'b1111, GBL,  1'b1, 1'b0);
    @(posedge clk); #1; load = 1'b0;
    while (cyc < c0 + 5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; rel = cyc;
    run_scan("restart", {G0, G0, G0, G0}, 4'b0000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end
endmodule
